// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: sequencing, microcode-load and control-word bus of the micro-sequencer
interface micro_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
);
  logic                     start;
  logic                     stall;
  logic [ADDR_W-1:0]        next_addr;
  logic                     uc_we;
  logic [ADDR_W-1:0]        uc_waddr;
  logic [CTRL_W+ADDR_W+1:0] uc_wdata;
  logic [ADDR_W-1:0]        car;
  logic [ADDR_W-1:0]        naddr;
  logic                     br;
  logic [CTRL_W-1:0]        ctrl;
  logic                     ctrl_valid;
  logic                     busy;
  logic                     halted;
  logic                     uc_wr_err;
  logic [CNT_W-1:0]         ucount;
  modport master (
    output start, stall, next_addr, uc_we, uc_waddr, uc_wdata,
    input  car, naddr, br, ctrl, ctrl_valid, busy, halted, uc_wr_err, ucount
  );
  modport slave (
    input  start, stall, next_addr, uc_we, uc_waddr, uc_wdata,
    output car, naddr, br, ctrl, ctrl_valid, busy, halted, uc_wr_err, ucount
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-address register and writable control store issuing one microinstruction per cycle
module micro_sequencer #(
  parameter int                ADDR_W     = 5,
  parameter int                CTRL_W     = 24,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                CNT_W      = 16
) (
  input logic              clk,
  input logic              reset_n,
  micro_sequencer_if.slave bus
);
  localparam int W = CTRL_W + ADDR_W + 2;
  typedef enum logic [1:0] {IDLE, RUN, STALL, HALT} state_t;
  state_t            state, nxt;
  logic [W-1:0]      store [2**ADDR_W];
  logic [W-1:0]      cw_q, cw_n;
  logic [ADDR_W-1:0] car_q, car_n;
  logic [CNT_W-1:0]  cnt;
  logic              ctrl_valid_q, busy_q, halted_q, err_q;
  logic              loadable, go, adv;
  always_comb begin
    loadable = state == IDLE || state == HALT;
    go       = loadable && bus.start;
    adv      = state == RUN && !bus.stall && !cw_q[W-1];
    nxt      = go ? RUN
             : state == RUN   ? (bus.stall ? STALL : cw_q[W-1] ? HALT : RUN)
             : state == STALL ? (bus.stall ? STALL : RUN)
             : state;
    car_n    = go ? START_ADDR : adv ? bus.next_addr : car_q;
    cw_n     = (go || adv) ? store[car_n] : cw_q;
  end
  // The halt word itself is not executed: it neither qualifies ctrl nor counts.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      car_q        <= '0;
      cw_q         <= '0;
      cnt          <= '0;
      ctrl_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= nxt;
      car_q        <= car_n;
      cw_q         <= cw_n;
      cnt          <= go ? '0 : (adv && !(&cnt)) ? cnt + 1'b1 : cnt;
      ctrl_valid_q <= nxt == RUN && !cw_n[W-1];
      busy_q       <= nxt == RUN || nxt == STALL;
      halted_q     <= nxt == HALT;
      err_q        <= bus.uc_we && !loadable;
    end
  always_ff @(posedge clk)
    if (bus.uc_we && loadable) store[bus.uc_waddr] <= bus.uc_wdata;
  assign bus.car        = car_q;
  assign bus.naddr      = cw_q[CTRL_W +: ADDR_W];
  assign bus.br         = cw_q[W-2];
  assign bus.ctrl       = cw_q[CTRL_W-1:0];
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.uc_wr_err  = err_q;
  assign bus.ucount     = cnt;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table, hand-sequence and random checks of micro_sequencer against a program-level model
module tb_micro_sequencer;
  localparam int AW = 5, CW = 24, NW = 6, W = CW + AW + 2;
  logic clk = 1'b0;
  logic reset_n;
  logic use_logic, z;
  logic [AW-1:0] ir, na_drv;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  micro_sequencer_if #(.ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) bus ();
  micro_sequencer #(.ADDR_W(AW), .CTRL_W(CW), .START_ADDR(5'd0), .CNT_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  // Stand-in for the next-address Logic: a taken branch (br && !Z) dispatches to IR.
  assign bus.next_addr = use_logic ? ((bus.br && !z) ? ir : bus.naddr) : na_drv;
  logic [W-1:0]  m_store [32];
  logic [W-1:0]  m_cw;
  logic [AW-1:0] m_car;
  logic [NW-1:0] m_cnt;
  bit            m_err, active, frozen, stopped;
  typedef struct {
    bit start; bit stall; int car; bit valid; bit halted; bit busy; int cnt;
  } vec_t;
  vec_t tbl [16];
  function automatic vec_t v(bit s, bit st, int c, bit va, bit h, bit b, int n);
    vec_t r;
    r.start = s; r.stall = st; r.car = c; r.valid = va; r.halted = h; r.busy = b; r.cnt = n;
    return r;
  endfunction
  function automatic logic [W-1:0] mk(bit h, bit b, int na, int c);
    return {h, b, AW'(na), CW'(c)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    active = 0; frozen = 0; stopped = 0; m_err = 0;
    m_car = '0; m_cw = '0; m_cnt = '0;
  endtask
  task automatic model_step();
    logic [AW-1:0] target;
    bit wr_ok;
    target = use_logic ? ((m_cw[W-2] && !z) ? ir : m_cw[CW +: AW]) : na_drv;
    wr_ok  = bus.uc_we && !active;
    m_err  = bus.uc_we && active;
    if (!active && bus.start) begin
      active = 1; frozen = 0; stopped = 0; m_car = '0; m_cw = m_store[0]; m_cnt = '0;
    end else if (active && frozen) frozen = bus.stall;
    else if (active && bus.stall) frozen = 1;
    else if (active && m_cw[W-1]) begin active = 0; stopped = 1; end
    else if (active) begin
      if (m_cnt != '1) m_cnt++;
      m_car = target;
      m_cw  = m_store[target];
    end
    if (wr_ok) m_store[bus.uc_waddr] = bus.uc_wdata;
  endtask
  task automatic check_all();
    chk("car",        32'(bus.car),        32'(m_car));
    chk("naddr",      32'(bus.naddr),      32'(m_cw[CW +: AW]));
    chk("br",         32'(bus.br),         32'(m_cw[W-2]));
    chk("ctrl",       32'(bus.ctrl),       32'(m_cw[CW-1:0]));
    chk("ctrl_valid", 32'(bus.ctrl_valid), 32'(active && !frozen && !m_cw[W-1]));
    chk("busy",       32'(bus.busy),       32'(active));
    chk("halted",     32'(bus.halted),     32'(stopped));
    chk("uc_wr_err",  32'(bus.uc_wr_err),  32'(m_err));
    chk("ucount",     32'(bus.ucount),     32'(m_cnt));
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset_car", 32'(bus.car), 32'd0);
    chk("reset_ucount", 32'(bus.ucount), 32'd0);
    #2 reset_n = 1'b1;
  endtask
  task automatic wr(input int a, input logic [W-1:0] d);
    bus.uc_we = 1'b1; bus.uc_waddr = AW'(a); bus.uc_wdata = d;
    tick();
    bus.uc_we = 1'b0;
  endtask
  task automatic run_to_halt();
    for (int k = 0; k < 64 && active; k++) tick();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0; bus.stall = 0; bus.uc_we = 0; bus.uc_waddr = '0; bus.uc_wdata = '0;
    use_logic = 1; z = 0; ir = '0; na_drv = '0;
    for (int i = 0; i < 32; i++) m_store[i] = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all();
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++)
      wr(i, i == 0 ? mk(0, 0, 1, 'h100) : i == 1 ? mk(0, 0, 2, 'h201) :
            i == 2 ? mk(0, 0, 3, 'h302) : i == 3 ? mk(1, 0, 3, 'h403) :
            i == 9 ? mk(0, 1, 11, 'h999) : i == 11 ? mk(1, 0, 0, 'hBBB) : mk(1, 0, 0, i));
    tbl[0]  = v(1, 0, 0, 1, 0, 1, 0);
    tbl[1]  = v(0, 0, 1, 1, 0, 1, 1);
    tbl[2]  = v(0, 0, 2, 1, 0, 1, 2);
    tbl[3]  = v(0, 0, 3, 0, 0, 1, 3);
    tbl[4]  = v(0, 0, 3, 0, 1, 0, 3);
    tbl[5]  = v(0, 0, 3, 0, 1, 0, 3);
    tbl[6]  = v(1, 0, 0, 1, 0, 1, 0);
    tbl[7]  = v(0, 0, 1, 1, 0, 1, 1);
    tbl[8]  = v(0, 0, 2, 1, 0, 1, 2);
    tbl[9]  = v(0, 1, 2, 0, 0, 1, 2);
    tbl[10] = v(0, 1, 2, 0, 0, 1, 2);
    tbl[11] = v(0, 1, 2, 0, 0, 1, 2);
    tbl[12] = v(0, 1, 2, 0, 0, 1, 2);
    tbl[13] = v(0, 0, 2, 1, 0, 1, 2);
    tbl[14] = v(0, 0, 3, 0, 0, 1, 3);
    tbl[15] = v(0, 0, 3, 0, 1, 0, 3);
    for (int i = 0; i < 16; i++) begin
      bus.start = tbl[i].start; bus.stall = tbl[i].stall;
      tick();
      chk("tbl_car",    32'(bus.car),        32'(tbl[i].car));
      chk("tbl_valid",  32'(bus.ctrl_valid), 32'(tbl[i].valid));
      chk("tbl_halted", 32'(bus.halted),     32'(tbl[i].halted));
      chk("tbl_busy",   32'(bus.busy),       32'(tbl[i].busy));
      chk("tbl_ucount", 32'(bus.ucount),     32'(tbl[i].cnt));
    end
    bus.start = 0; bus.stall = 0;
    wr(0, mk(0, 0, 9, 'h090));
    ir = 5'd9; z = 0;
    bus.start = 1; tick(); bus.start = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin bus.uc_we = 1; bus.uc_waddr = 5'd5; bus.uc_wdata = mk(0, 0, 0, 'hDEAD5); end
      tick();
      bus.uc_we = 0;
      chk("branch_hold", 32'(bus.car), 32'd9);
      chk("wr_err_pulse", 32'(bus.uc_wr_err), 32'(k == 1));
    end
    z = 1; tick();
    chk("branch_taken", 32'(bus.car), 32'd11);
    tick();
    chk("branch_halt", 32'(bus.halted), 32'd1);
    z = 0;
    wr(0, mk(0, 0, 5, 'h050));
    bus.start = 1; tick(); bus.start = 0;
    tick();
    chk("readback_ctrl", 32'(bus.ctrl), 32'd5);
    run_to_halt();
    bus.uc_we = 1; bus.uc_waddr = 5'd0; bus.uc_wdata = mk(0, 0, 1, 'hABC); bus.start = 1;
    tick();
    bus.uc_we = 0; bus.start = 0;
    chk("wr_start_old", 32'(bus.ctrl), 32'h050);
    run_to_halt();
    wr(7, mk(0, 0, 7, 'h777));
    wr(0, mk(0, 0, 7, 'h070));
    bus.start = 1; tick(); bus.start = 0;
    for (int k = 0; k < 70; k++) begin
      bus.start = k == 10;
      tick();
    end
    bus.start = 0;
    chk("sat_ucount", 32'(bus.ucount), 32'd63);
    chk("start_ignored", 32'(bus.car), 32'd7);
    async_reset();
    bus.start = 1; tick(); bus.start = 0;
    chk("store_kept", 32'(bus.ctrl), 32'h070);
    async_reset();
    for (int i = 0; i < 32; i++) wr(i, {$urandom_range(0, 7) == 0, 30'($urandom)});
    for (int n = 0; n < 3000; n++) begin
      bus.start    = $urandom_range(0, 9) == 0;
      bus.stall    = $urandom_range(0, 3) == 0;
      bus.uc_we    = $urandom_range(0, 5) == 0;
      bus.uc_waddr = AW'($urandom);
      bus.uc_wdata = {$urandom_range(0, 7) == 0, 30'($urandom)};
      na_drv = AW'($urandom); ir = AW'($urandom); z = 1'($urandom); use_logic = 1'($urandom);
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
